store_buffer: RTL and testbench

- Posted-write buffer between the mem stage and the data ram.
- The mem stage pushes stores into a small circular FIFO and continues without waiting.
- A drain state machine retires the stores to ram in order, one per ram handshake.
- Stalls the pipeline when full; an optional feature forwards buffered data to loads.

---
 rtl/store_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_store_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the mem stage and the data ram, drained in order.
// Define SB_FWD_EN to forward fully covered buffered data to matching loads instead of stalling.
module store_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              st_req_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [3:0]        st_be_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [3:0]        ld_be_i,
  output logic              stall_o,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic [3:0]        ram_be_o,
  input  logic              ram_ack_i,
  output logic              empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = ADDR_W - 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [WW-1:0]     r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [3:0]        r_be   [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [0:0]        r_state;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data;
  logic [3:0]        r_ram_be;
  logic              r_empty;

  logic              w_pop;
  logic              w_push;
  logic              w_full_stall;
  logic              w_ld_stall;
  logic              w_ld_match;
  logic [PW-1:0]     w_idx;
  logic [3:0]        w_sel_be;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic [CW-1:0]     w_count_nxt;
  logic [0:0]        w_state_nxt;
  logic              w_load_ram;

  assign w_pop        = (r_state == S_WRITE) && ram_ack_i;
  assign w_full_stall = st_req_i && (r_count == FULL_CNT) && !w_pop;
  assign stall_o      = w_full_stall | w_ld_stall;
  assign w_push       = st_req_i && !stall_o;

  // Scan oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    w_ld_match = 1'b0;
    w_sel_be   = 4'h0;
    w_sel_data = {DATA_W{1'b0}};
    w_idx      = r_rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PW'(k);
      if ((CW'(k) < r_count) && r_valid[w_idx] &&
          (r_addr[w_idx] == ld_addr_i[ADDR_W-1:2])) begin
        w_ld_match = 1'b1;
        w_sel_be   = r_be[w_idx];
        w_sel_data = r_data[w_idx];
      end else begin
        w_ld_match = w_ld_match;
      end
    end
  end

  // Load hazard resolution: forward on full byte coverage, otherwise hold the load.
  always_comb begin
    w_ld_stall = 1'b0;
    w_fwd_hit  = 1'b0;
    w_fwd_data = {DATA_W{1'b0}};
`ifdef SB_FWD_EN
    if (ld_req_i && w_ld_match) begin
      if ((ld_be_i & ~w_sel_be) == 4'h0) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_sel_data;
      end else begin
        w_ld_stall = 1'b1;
      end
    end else begin
      w_ld_stall = 1'b0;
    end
`else
    w_ld_stall = ld_req_i && w_ld_match;
`endif
  end

`ifdef SB_FWD_EN
  logic w_unused;
  assign w_unused = &{1'b0, st_addr_i[1:0], ld_addr_i[1:0]};
`else
  logic w_unused;
  assign w_unused = &{1'b0, st_addr_i[1:0], ld_addr_i[1:0], ld_be_i, w_sel_be, w_sel_data};
`endif

  assign fwd_hit_o  = w_fwd_hit;
  assign fwd_data_o = w_fwd_data;

  // Drain sequencing and occupancy bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_load_ram  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != {CW{1'b0}}) begin
          w_state_nxt = S_WRITE;
          w_load_ram  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        if (ram_ack_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1'b1);
      2'b01:   w_count_nxt = r_count - CW'(1'b1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry payload needs no reset; validity and pointers guard every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= st_addr_i[ADDR_W-1:2];
      r_data[r_wr_ptr] <= st_data_i;
      r_be[r_wr_ptr]   <= st_be_i;
    end
  end

  // Pop clears before push sets, so a same-slot replace on a full buffer stays valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid  <= {DEPTH{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PW'(1'b1);
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PW'(1'b1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Ram-side registers: the head is captured on entering WRITE and held until acked.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_ram_we   <= 1'b0;
      r_ram_addr <= {ADDR_W{1'b0}};
      r_ram_data <= {DATA_W{1'b0}};
      r_ram_be   <= 4'h0;
      r_empty    <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_ram_we <= (w_state_nxt == S_WRITE);
      r_empty  <= (w_count_nxt == {CW{1'b0}}) && (w_state_nxt == S_IDLE);
      if (w_load_ram) begin
        r_ram_addr <= {r_addr[r_rd_ptr], 2'b00};
        r_ram_data <= r_data[r_rd_ptr];
        r_ram_be   <= r_be[r_rd_ptr];
      end
    end
  end

  assign ram_we_o   = r_ram_we;
  assign ram_addr_o = r_ram_addr;
  assign ram_data_o = r_ram_data;
  assign ram_be_o   = r_ram_be;
  assign empty_o    = r_empty;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_req, ld_req, ram_ack;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [3:0]  st_be, ld_be;
  logic        stall, fwd_hit, ram_we, empty;
  logic [31:0] fwd_data, ram_addr, ram_data;
  logic [3:0]  ram_be;

  store_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .st_req_i(st_req), .st_addr_i(st_addr), .st_data_i(st_data), .st_be_i(st_be),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_be_i(ld_be),
    .stall_o(stall), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_be_o(ram_be),
    .ram_ack_i(ram_ack), .empty_o(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  be;
  } sb_ent_t;

  sb_ent_t     mq[$];
  bit          m_active;
  bit          rand_ack;
  logic        obs_stall, obs_hit;
  logic [31:0] obs_fdata;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic cycle(output bit accepted);
    bit pop, st_stall, ld_stall, hit;
    logic [31:0] fd;
    int n, y;
    sb_ent_t e;
    if (rand_ack) ram_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    n = mq.size();
    pop = m_active && ram_ack;
    ld_stall = 1'b0; hit = 1'b0; fd = 32'h0; y = -1;
    if (ld_req) begin
      for (int i = 0; i < n; i++) if (mq[i].wa == ld_addr[31:2]) y = i;
      if (y >= 0) begin
`ifdef SB_FWD_EN
        if ((ld_be & ~mq[y].be) == 4'h0) begin hit = 1'b1; fd = mq[y].d; end
        else ld_stall = 1'b1;
`else
        ld_stall = 1'b1;
`endif
      end
    end
    st_stall = st_req && (n == DEPTH) && !pop;
    obs_stall = stall; obs_hit = fwd_hit; obs_fdata = fwd_data;
    chk("stall", stall, st_stall || ld_stall);
    chk("fwd_hit", fwd_hit, hit);
    chk("fwd_data", fwd_data, fd);
    chk("ram_we", ram_we, m_active);
    if (m_active && n > 0) begin
      chk("ram_addr", ram_addr, {mq[0].wa, 2'b00});
      chk("ram_data", ram_data, mq[0].d);
      chk("ram_be", ram_be, mq[0].be);
    end
    chk("empty", empty, (n == 0) && !m_active);
    accepted = st_req && !(st_stall || ld_stall);
    if (pop) void'(mq.pop_front());
    if (pop) m_active = 1'b0;
    else if (!m_active && n > 0) m_active = 1'b1;
    if (accepted) begin
      e.wa = st_addr[31:2]; e.d = st_data; e.be = st_be;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bit acc;
    int t;
    st_req = 1'b1; st_addr = a; st_data = d; st_be = b; acc = 1'b0; t = 0;
    while (!acc && t < 100) begin cycle(acc); t++; end
    chk("store_accept_bound", obs_stall, 1'b0);
    st_req = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] b);
    bit acc;
    int t;
    ld_req = 1'b1; ld_addr = a; ld_be = b;
    cycle(acc); t = 1;
    while (obs_stall && t < 100) begin cycle(acc); t++; end
    chk("load_release_bound", obs_stall, 1'b0);
    ld_req = 1'b0;
  endtask

  initial begin
    bit acc;
    int t, op;
    rst = 1'b1; st_req = 1'b0; ld_req = 1'b0; ram_ack = 1'b0; rand_ack = 1'b0;
    st_addr = 32'h0; st_data = 32'h0; st_be = 4'h0; ld_addr = 32'h0; ld_be = 4'h0;
    m_active = 1'b0;
    #3;
    chk("rst_we", ram_we, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single store with ack tied high: model expects we exactly at N+2 for one cycle
    ram_ack = 1'b1;
    do_store(32'h0000_0104, 32'hDEAD_BEEF, 4'hF);
    idle(5);

    // Full and wrap
    ram_ack = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_store(32'h10 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
    st_req = 1'b1; st_addr = 32'h20; st_data = 32'hA000_0004; st_be = 4'hF;
    cycle(acc);
    chk("full_stall", obs_stall, 1'b1);
    ram_ack = 1'b1;
    cycle(acc);
    chk("full_replace_no_stall", obs_stall, 1'b0);
    st_req = 1'b0;
    for (int i = 0; i < 6; i++) do_store(32'h40 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'(i + 1));
    idle(20);

    // Load hazard
    ram_ack = 1'b0;
    do_store(32'h200, 32'hCAFE_F00D, 4'hF);
    idle(2);
    ld_req = 1'b1; ld_addr = 32'h202; ld_be = 4'h4;
    idle(3);
`ifdef SB_FWD_EN
    chk("ld_fwd_hit", obs_hit, 1'b1);
    chk("ld_fwd_data", obs_fdata, 32'hCAFE_F00D);
`else
    chk("ld_hazard_stall", obs_stall, 1'b1);
`endif
    ram_ack = 1'b1;
    t = 0;
    cycle(acc);
    while (obs_stall && t < 20) begin cycle(acc); t++; end
    chk("ld_hazard_release", obs_stall, 1'b0);
    ld_addr = 32'h204;
    cycle(acc);
    chk("ld_nomatch", obs_stall, 1'b0);
    ld_req = 1'b0;
    idle(6);

    // Forwarding youngest match and partial coverage
    ram_ack = 1'b0;
    do_store(32'h300, 32'h1111_1111, 4'hF);
    do_store(32'h300, 32'h2222_2222, 4'hF);
    ld_req = 1'b1; ld_addr = 32'h300; ld_be = 4'hF;
    cycle(acc);
`ifdef SB_FWD_EN
    chk("fwd_young_hit", obs_hit, 1'b1);
    chk("fwd_young_data", obs_fdata, 32'h2222_2222);
`else
    chk("nofwd_stall", obs_stall, 1'b1);
`endif
    ld_req = 1'b0;
    do_store(32'h400, 32'h3333_3333, 4'h3);
    ld_req = 1'b1; ld_addr = 32'h400; ld_be = 4'hF;
    cycle(acc);
    chk("partial_stall", obs_stall, 1'b1);
    chk("partial_no_hit", obs_hit, 1'b0);
    ld_req = 1'b0;
    ram_ack = 1'b1;
    idle(12);

    // Reset mid-WRITE with three entries buffered
    ram_ack = 1'b0;
    for (int i = 0; i < 3; i++) do_store(32'h500 + 32'(i * 4), 32'h5500_0000 + 32'(i), 4'hF);
    idle(2);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", ram_we, 1'b0);
    chk("mid_rst_addr", ram_addr, 32'h0);
    chk("mid_rst_data", ram_data, 32'h0);
    chk("mid_rst_be", ram_be, 4'h0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_fwd", {fwd_hit, fwd_data}, 33'h0);
    mq.delete();
    m_active = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ram_ack = 1'b1;
    idle(6);

    // Random traffic with random ack
    rand_ack = 1'b1;
    for (int it = 0; it < 600; it++) begin
      op = $urandom_range(0, 9);
      if (op < 4)
        do_store(32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                 $urandom, 4'($urandom_range(0, 15)));
      else if (op < 6)
        do_load(32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                4'($urandom_range(1, 15)));
      else
        idle(1);
    end
    rand_ack = 1'b0;
    ram_ack = 1'b1;
    idle(12);
    chk("final_empty", empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
